// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - fetch-unit bus: ID control, instruction memory and ID-facing outputs
// slave is the fetch unit; master is whatever drives stall/redirect and models the memory.
interface if_fetch_unit_if #(
  parameter int CNT_W = 16
) ();
  logic             stall_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             imem_req_o;
  logic [31:0]      imem_addr_o;
  logic [31:0]      imem_rdata_i;
  logic             id_valid_o;
  logic [31:0]      id_instr_o;
  logic [31:0]      id_pc_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, stall_cnt_o
  );

  modport master (
    output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, stall_cnt_o
  );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with credit-limited prefetch queue
// Owns the PC, issues 1-cycle-latency reads and feeds ID from a small FIFO; redirect flushes.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4,
  parameter int          CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  if_fetch_unit_if.slave bus
);
  localparam int AW = $clog2(FQ_DEPTH);

  logic [31:0]      r_pc;
  logic [31:0]      r_tag_pc;
  logic             r_tag_epoch;
  logic             r_epoch;
  logic             r_inflight;
  logic [AW:0]      r_occ;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [31:0]      r_q_instr [FQ_DEPTH];
  logic [31:0]      r_q_pc    [FQ_DEPTH];

  logic [AW+1:0]    w_used;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;

  // Credits count buffered words plus the one possibly in flight, so a push always has room.
  assign w_used  = {1'b0, r_occ} + (AW+2)'(r_inflight);
  assign w_issue = rst_n & ~bus.redirect_i & (w_used < (AW+2)'(FQ_DEPTH));
  assign w_valid = (r_occ != '0);
  assign w_push  = r_inflight & (r_tag_epoch == r_epoch) & ~bus.redirect_i;
  assign w_pop   = w_valid & ~bus.stall_i & ~bus.redirect_i;

  assign bus.imem_req_o  = w_issue;
  assign bus.imem_addr_o = r_pc;
  assign bus.id_valid_o  = w_valid;
  assign bus.id_instr_o  = w_valid ? r_q_instr[r_rd] : 32'h0;
  assign bus.id_pc_o     = w_valid ? r_q_pc[r_rd]    : 32'h0;
  assign bus.stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= {RESET_PC[31:2], 2'b00};
      r_tag_pc    <= 32'h0;
      r_tag_epoch <= 1'b0;
      r_epoch     <= 1'b0;
      r_inflight  <= 1'b0;
      r_occ       <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (bus.redirect_i) begin
        // Epoch flip marks anything still returning as belonging to the old path.
        r_occ      <= '0;
        r_rd       <= '0;
        r_wr       <= '0;
        r_inflight <= 1'b0;
        r_epoch    <= ~r_epoch;
        r_pc       <= {bus.redirect_pc_i[31:2], 2'b00};
      end else begin
        if (w_issue) begin
          r_pc        <= r_pc + 32'd4;
          r_tag_pc    <= r_pc;
          r_tag_epoch <= r_epoch;
        end
        r_inflight <= w_issue;
        if (w_push) begin
          r_wr <= r_wr + AW'(1);
        end
        if (w_pop) begin
          r_rd <= r_rd + AW'(1);
        end
        r_occ <= r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
      if (w_valid && bus.stall_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr] <= bus.imem_rdata_i;
      r_q_pc[r_wr]    <= r_tag_pc;
    end
  end
endmodule
